// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - HDMI raster generator realigned by vreset, with lock tracking and slip counting
module hdmi_video_timing #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vreset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  slip_cnt
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic        vreset_d;
    state_t      state, state_nx;
    logic [3:0]  settle_cnt, settle_nx;

    logic at_end;
    logic vr_edge;
    logic misaligned;

    // The last pixel of the frame is the only position where a realign is seamless.
    assign at_end     = (hcnt == 12'(HT - 1)) && (vcnt == 11'(VT - 1));
    assign vr_edge    = vreset && !vreset_d;
    assign misaligned = vr_edge && !at_end;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hcnt     <= '0;
            vcnt     <= '0;
            vreset_d <= 1'b0;
        end else begin
            vreset_d <= vreset;
            if (vreset) begin
                hcnt <= '0;
                vcnt <= '0;
            end else if (hcnt == 12'(HT - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == 11'(VT - 1)) ? 11'd0 : vcnt + 11'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end
        end
    end

    // Every output is decoded from the same counter value so they stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            de          <= 1'b0;
            hs          <= !HS_POL;
            vs          <= !VS_POL;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            de          <= (hcnt < 12'(H_ACTIVE)) && (vcnt < 11'(V_ACTIVE));
            hs          <= ((hcnt >= 12'(H_ACTIVE + H_FP)) &&
                            (hcnt < 12'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : !HS_POL;
            vs          <= ((vcnt >= 11'(V_ACTIVE + V_FP)) &&
                            (vcnt < 11'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : !VS_POL;
            x           <= hcnt;
            y           <= vcnt;
            frame_start <= (hcnt == 12'd0) && (vcnt == 11'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= HUNT;
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            locked     <= (state_nx == LOCKED);
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        case (state)
            HUNT: begin
                if (vr_edge) begin
                    state_nx  = SETTLE;
                    settle_nx = '0;
                end
            end
            SETTLE: begin
                if (misaligned) begin
                    settle_nx = '0;
                end else if (at_end) begin
                    if (settle_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
                        state_nx  = LOCKED;
                        settle_nx = '0;
                    end else begin
                        settle_nx = settle_cnt + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (misaligned) begin
                    state_nx  = SETTLE;
                    settle_nx = '0;
                end
            end
            default: begin
                state_nx  = HUNT;
                settle_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            slip_cnt <= '0;
        end else if (misaligned && (slip_cnt != 8'hff)) begin
            slip_cnt <= slip_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb/tb_hdmi_video_timing.sv - directed bench for hdmi_video_timing on a shrunken 16x8 raster
module tb_hdmi_video_timing;

    localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vreset = 1'b0;
    logic        hs, vs, de, frame_start, locked;
    logic [11:0] x;
    logic [10:0] y;
    logic [7:0]  slip_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int pos = 0;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .vreset(vreset),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .locked(locked), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {frame_start, de, hs, vs, x, y} for a raster position
    function automatic logic [26:0] vec(input int p);
        int  h, v;
        logic hs_e, vs_e, de_e;
        h    = p % HT;
        v    = p / HT;
        de_e = (h < HA) && (v < VA);
        hs_e = (h >= HA + HF && h < HA + HF + HSY) ? HS_POL : !HS_POL;
        vs_e = (v >= VA + VF && v < VA + VF + VSY) ? VS_POL : !VS_POL;
        return {p == 0, de_e, hs_e, vs_e, 12'(h), 11'(v)};
    endfunction

    task automatic tick();
        logic [26:0] ev;
        if (!resetn) begin
            ev  = {1'b0, 1'b0, !HS_POL, !VS_POL, 12'd0, 11'd0};
            pos = 0;
        end else begin
            ev  = vec(pos);
            pos = vreset ? 0 : (pos + 1) % FT;
        end
        @(posedge clk);
        #1;
        check("raster", {5'd0, frame_start, de, hs, vs, x, y}, {5'd0, ev});
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < FT && pos != p; i++) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_slip", 32'(slip_cnt), 32'd0);

        // free run from reset with hand-picked spot checks
        resetn = 1'b1;
        for (int t = 1; t <= 130; t++) begin
            tick();
            if (t == 1)   check("first_fs", {29'd0, frame_start, de, hs}, {29'd0, 3'b110});
            if (t == 8)   check("de_last", 32'(de), 32'd1);
            if (t == 9)   check("de_off", 32'(de), 32'd0);
            if (t == 11)  check("hs_on", {31'd0, hs}, 32'd1);
            if (t == 14)  check("hs_off", {31'd0, hs}, 32'd0);
            if (t == 81)  check("vs_on", {31'd0, vs}, 32'd0);
            if (t == 113) check("vs_off", {31'd0, vs}, 32'd1);
            if (t == 128) check("frame_end", {8'd0, frame_start, x, y}, {8'd0, 1'b0, 12'd15, 11'd7});
            if (t == 129) check("frame_period", 32'(frame_start), 32'd1);
            if (locked) check("locked_free", 32'(locked), 32'd0);
        end

        // misaligned pulse in HUNT, then lock after two natural wraps
        advance_to(2 * HT + 5);
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        check("slip_1", 32'(slip_cnt), 32'd1);
        for (int i = 0; i < 255; i++) tick();
        check("pre_lock", 32'(locked), 32'd0);
        tick();
        check("lock_rise", 32'(locked), 32'd1);

        // aligned pulse keeps lock and raster
        advance_to(FT - 1);
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        check("aligned_slip", 32'(slip_cnt), 32'd1);
        check("aligned_lock", 32'(locked), 32'd1);
        repeat (5) tick();
        check("aligned_lock2", 32'(locked), 32'd1);

        // vreset held three cycles mid-frame
        advance_to(50);
        vreset = 1'b1;
        tick();
        check("hold_t1", {19'd0, frame_start, x}, {19'd0, 1'b0, 12'd2});
        check("hold_unlock", 32'(locked), 32'd0);
        tick();
        check("hold_fs2", 32'(frame_start), 32'd1);
        tick();
        check("hold_fs3", 32'(frame_start), 32'd1);
        vreset = 1'b0;
        tick();
        check("hold_fs4", 32'(frame_start), 32'd1);
        tick();
        check("hold_x1", {19'd0, frame_start, x}, {19'd0, 1'b0, 12'd1});
        check("hold_slip", 32'(slip_cnt), 32'd2);

        // saturation
        for (int i = 0; i < 300; i++) begin
            tick();
            tick();
            vreset = 1'b1;
            tick();
            vreset = 1'b0;
            if (i == 251) check("slip_254", 32'(slip_cnt), 32'd254);
        end
        check("slip_sat", 32'(slip_cnt), 32'd255);
        check("sat_unlocked", 32'(locked), 32'd0);

        // reset overrides vreset while locked
        for (int i = 0; i < 300; i++) tick();
        check("relock", 32'(locked), 32'd1);
        advance_to(40);
        resetn = 1'b0;
        vreset = 1'b1;
        tick();
        check("rst2_locked", 32'(locked), 32'd0);
        check("rst2_slip", 32'(slip_cnt), 32'd0);
        vreset = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("hunt_after_rst", 32'(locked), 32'd0);
        check("slip_after_rst", 32'(slip_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
